// File: rtl/encode_align_pkg.sv
// Shared types and helpers for the encoder delay aligner.
package encode_align_pkg;

    localparam int DEF_DATA_WIDTH = 36;
    localparam int DEF_DEPTH      = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } align_state_e;

    // Limit a requested delay to what the buffer can hold (DEPTH-1 entries in flight).
    function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned depth);
        return (req > depth - 1) ? depth - 1 : req;
    endfunction

endpackage

// File: rtl/encode_delay_align_if.sv
// Sample/control bundle between the encoder receiver, the aligner and the scan consumers.
// Carries sim_en_i only when ENCODE_ALIGN_SIM_EN is defined.
interface encode_delay_align_if
    import encode_align_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);
    localparam int AW = $clog2(DEPTH);

`ifdef ENCODE_ALIGN_SIM_EN
    logic                  sim_en_i;
`endif
    logic                  flush_i;
    logic [AW-1:0]         delay_set_i;
    logic                  din_en_i;
    logic [DATA_WIDTH-1:0] din_i;
    logic                  scan_en_i;
    logic                  dout_en_o;
    logic [DATA_WIDTH-1:0] dout_o;
    logic                  aligned_o;
    logic [AW:0]           fill_level_o;
    logic [AW-1:0]         delay_act_o;

    modport master (
`ifdef ENCODE_ALIGN_SIM_EN
        output sim_en_i,
`endif
        output flush_i, delay_set_i, din_en_i, din_i, scan_en_i,
        input  dout_en_o, dout_o, aligned_o, fill_level_o, delay_act_o
    );

    modport slave (
`ifdef ENCODE_ALIGN_SIM_EN
        input  sim_en_i,
`endif
        input  flush_i, delay_set_i, din_en_i, din_i, scan_en_i,
        output dout_en_o, dout_o, aligned_o, fill_level_o, delay_act_o
    );

endinterface

// File: rtl/encode_delay_ram.sv
// Simple dual-port sample buffer with a registered read port; maps onto block RAM.
module encode_delay_ram #(
    parameter  int DATA_WIDTH = 36,
    parameter  int DEPTH      = 4096,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // write port
    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    // registered read port; holds its value between reads
    always_ff @(posedge clk_i) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/encode_delay_align.sv
// Encoder sample delay line: emits each strobed word exactly D strobes later,
// D latched from delay_set_i when a fill starts. Two-cycle latency from the
// read-triggering strobe to dout_o. ENCODE_ALIGN_SIM_EN adds a counter test source.
module encode_delay_align
    import encode_align_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input logic                  clk_i,
    input logic                  rst_i,
    encode_delay_align_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    align_state_e          state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         dly_q, dly_d;
    logic [AW-1:0]         d_clamp;
    logic                  flush_req;
    logic                  in_en;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  ram_we, ram_re, byp, rd_fire;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  vld_s1, byp_s1;
    logic [DATA_WIDTH-1:0] byp_data_s1;
    logic                  dout_en_q, aligned_q;
    logic [DATA_WIDTH-1:0] dout_q;

`ifdef ENCODE_ALIGN_SIM_EN
    logic [DATA_WIDTH-1:0] sim_cnt_q;

    // ramp source, held at zero whenever sim mode is off
    always_ff @(posedge clk_i) begin
        if (rst_i || !bus.sim_en_i) sim_cnt_q <= '0;
        else                        sim_cnt_q <= sim_cnt_q + DATA_WIDTH'(1);
    end

    assign in_en   = bus.sim_en_i ? 1'b1 : bus.din_en_i;
    assign in_data = bus.sim_en_i ? sim_cnt_q : bus.din_i;
`else
    assign in_en   = bus.din_en_i;
    assign in_data = bus.din_i;
`endif

    assign d_clamp   = AW'(clamp_delay(32'(bus.delay_set_i), DEPTH));
    // a new delay request realigns just like an explicit flush
    assign flush_req = bus.flush_i || (d_clamp != dly_q);

    // state, pointers, count and latched delay
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dly_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
        end
    end

    // next state and buffer access; flush wins over a coincident strobe
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dly_d    = dly_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        byp      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_en) begin
                    dly_d = d_clamp;
                    if (d_clamp == '0) begin
                        // zero delay: sample goes round the RAM
                        byp     = 1'b1;
                        state_d = RUN;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        cnt_d    = CW'(1);
                        state_d  = FILL;
                    end
                end
            end
            FILL: begin
                if (flush_req) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                    state_d  = FLUSH;
                end else if (in_en) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (cnt_q == {1'b0, dly_q}) begin
                        ram_re   = 1'b1;
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        state_d  = RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RUN: begin
                if (flush_req) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                    state_d  = FLUSH;
                end else if (in_en) begin
                    if (dly_q == '0) begin
                        byp = 1'b1;
                    end else begin
                        ram_we   = 1'b1;
                        ram_re   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            FLUSH: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_fire = ram_re | byp;

    encode_delay_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // stage 1: tracks the RAM read cycle; bypass data rides alongside
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_s1      <= 1'b0;
            byp_s1      <= 1'b0;
            byp_data_s1 <= '0;
        end else begin
            vld_s1 <= rd_fire;
            byp_s1 <= byp;
            if (byp) byp_data_s1 <= in_data;
        end
    end

    // output register: data follows every valid, strobe is gated by scan_en_i
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_en_q <= 1'b0;
            dout_q    <= '0;
            aligned_q <= 1'b0;
        end else begin
            dout_en_q <= vld_s1 & bus.scan_en_i;
            if (vld_s1) dout_q <= byp_s1 ? byp_data_s1 : ram_rdata;
            aligned_q <= (state_d == RUN);
        end
    end

    assign bus.dout_en_o    = dout_en_q;
    assign bus.dout_o       = dout_q;
    assign bus.aligned_o    = aligned_q;
    assign bus.fill_level_o = cnt_q;
    assign bus.delay_act_o  = dly_q;

endmodule

// File: tb/tb_encode_delay_align.sv
// Directed bench for encode_delay_align; expectations are hand-derived per vector.
module tb_encode_delay_align;
    localparam int DW    = 36;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    encode_delay_align_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    encode_delay_align #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic en, input logic [DW-1:0] d);
        bus.din_en_i = en;
        bus.din_i    = d;
        tick();
        bus.din_en_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".dout_en"}, 64'(bus.dout_en_o), 64'd0);
        chk({tag, ".dout"},    64'(bus.dout_o),    64'd0);
        chk({tag, ".aligned"}, 64'(bus.aligned_o), 64'd0);
        chk({tag, ".fill"},    64'(bus.fill_level_o), 64'd0);
        chk({tag, ".dly_act"}, 64'(bus.delay_act_o),  64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
`ifdef ENCODE_ALIGN_SIM_EN
        bus.sim_en_i    = 1'b0;
`endif
        bus.flush_i     = 1'b0;
        bus.delay_set_i = '0;
        bus.din_en_i    = 1'b0;
        bus.din_i       = '0;
        bus.scan_en_i   = 1'b1;

        // reset state
        tick();
        tick();
        chk_zero("reset");

        // basic delay D=3, back-to-back strobes 1..8
        bus.delay_set_i = 12'd3;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, DW'(k));
            chk($sformatf("basic.fill%0d", k), 64'(bus.fill_level_o), 64'((k < 3) ? k : 3));
            chk($sformatf("basic.aligned%0d", k), 64'(bus.aligned_o), 64'(k >= 4));
            chk($sformatf("basic.en%0d", k), 64'(bus.dout_en_o), 64'(k >= 5));
            if (k >= 5) chk($sformatf("basic.dout%0d", k), 64'(bus.dout_o), 64'(k - 4));
        end
        step(1'b0, '0);
        chk("basic.tail_en", 64'(bus.dout_en_o), 64'd1);
        chk("basic.tail_dout", 64'(bus.dout_o), 64'd5);
        chk("basic.dly_act", 64'(bus.delay_act_o), 64'd3);
        step(1'b0, '0);
        chk("basic.idle_en", 64'(bus.dout_en_o), 64'd0);

        // scan gate low in RUN: data tracks, strobe suppressed
        bus.scan_en_i = 1'b0;
        step(1'b1, DW'(9));
        step(1'b0, '0);
        chk("gate3.en", 64'(bus.dout_en_o), 64'd0);
        chk("gate3.dout", 64'(bus.dout_o), 64'd6);
        bus.scan_en_i = 1'b1;

        // delay change 3 -> 5 while in RUN
        bus.delay_set_i = 12'd5;
        tick();
        chk("chg.flush_aligned", 64'(bus.aligned_o), 64'd0);
        chk("chg.flush_fill", 64'(bus.fill_level_o), 64'd0);
        tick();
        chk("chg.idle_fill", 64'(bus.fill_level_o), 64'd0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, DW'(100 + k));
            chk($sformatf("chg.en%0d", k), 64'(bus.dout_en_o), 64'd0);
            chk($sformatf("chg.fill%0d", k), 64'(bus.fill_level_o), 64'((k < 5) ? k : 5));
        end
        chk("chg.dly_act", 64'(bus.delay_act_o), 64'd5);
        chk("chg.aligned", 64'(bus.aligned_o), 64'd1);
        step(1'b0, '0);
        chk("chg.first_en", 64'(bus.dout_en_o), 64'd1);
        chk("chg.first_dout", 64'(bus.dout_o), 64'd101);

        // sparse strobes, D=2, one strobe every 5 cycles
        bus.delay_set_i = 12'd2;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, DW'(10 + i));
            chk($sformatf("sparse.s%0d_en0", i), 64'(bus.dout_en_o), 64'd0);
            step(1'b0, '0);
            chk($sformatf("sparse.s%0d_en1", i), 64'(bus.dout_en_o), 64'(i >= 2));
            if (i >= 2) chk($sformatf("sparse.s%0d_dout", i), 64'(bus.dout_o), 64'(10 + i - 2));
            for (int j = 2; j < 5; j++) begin
                step(1'b0, '0);
                chk($sformatf("sparse.s%0d_en%0d", i, j), 64'(bus.dout_en_o), 64'd0);
            end
        end

        // flush together with a strobe, then a strobe inside the flush cycle
        bus.delay_set_i = 12'd3;
        apply_reset();
        step(1'b1, DW'(1));
        step(1'b1, DW'(2));
        chk("coll.fill_pre", 64'(bus.fill_level_o), 64'd2);
        bus.flush_i = 1'b1;
        step(1'b1, DW'('h77));
        bus.flush_i = 1'b0;
        chk("coll.fill", 64'(bus.fill_level_o), 64'd0);
        chk("coll.aligned", 64'(bus.aligned_o), 64'd0);
        step(1'b1, DW'('h99));
        chk("coll.flushcyc_fill", 64'(bus.fill_level_o), 64'd0);
        for (int k = 1; k <= 4; k++) step(1'b1, DW'('h20 + k));
        chk("coll.refill", 64'(bus.fill_level_o), 64'd3);
        step(1'b0, '0);
        chk("coll.en", 64'(bus.dout_en_o), 64'd1);
        chk("coll.dout", 64'(bus.dout_o), 64'h21);

        // reset mid-RUN with a read in flight
        step(1'b1, DW'('h25));
        chk("rst.fill_pre", 64'(bus.fill_level_o), 64'd3);
        rst = 1'b1;
        tick();
        chk_zero("rst");
        rst = 1'b0;
        tick();
        chk("rst.stale_en", 64'(bus.dout_en_o), 64'd0);
        step(1'b1, DW'('h31));
        chk("rst.restart_fill", 64'(bus.fill_level_o), 64'd1);
        chk("rst.restart_aligned", 64'(bus.aligned_o), 64'd0);
        for (int j = 0; j < 2; j++) begin
            step(1'b0, '0);
            chk($sformatf("rst.quiet%0d", j), 64'(bus.dout_en_o), 64'd0);
        end

        // zero delay: bypass with the same 2-cycle latency
        bus.delay_set_i = 12'd0;
        apply_reset();
        step(1'b1, DW'('h55));
        chk("zero.aligned", 64'(bus.aligned_o), 64'd1);
        chk("zero.fill", 64'(bus.fill_level_o), 64'd0);
        step(1'b1, DW'('h66));
        chk("zero.en0", 64'(bus.dout_en_o), 64'd1);
        chk("zero.dout0", 64'(bus.dout_o), 64'h55);
        step(1'b1, DW'('h77));
        chk("zero.dout1", 64'(bus.dout_o), 64'h66);
        step(1'b0, '0);
        chk("zero.dout2", 64'(bus.dout_o), 64'h77);
        step(1'b0, '0);
        chk("zero.idle_en", 64'(bus.dout_en_o), 64'd0);
        bus.scan_en_i = 1'b0;
        step(1'b1, DW'('h88));
        step(1'b0, '0);
        chk("gate0.en", 64'(bus.dout_en_o), 64'd0);
        chk("gate0.dout", 64'(bus.dout_o), 64'h88);
        bus.scan_en_i = 1'b1;

        // maximum delay 4095: fill saturates at DEPTH-1
        bus.delay_set_i = 12'd4095;
        apply_reset();
        for (int i = 1; i <= 4095; i++) step(1'b1, DW'(i));
        chk("max.fill_full", 64'(bus.fill_level_o), 64'd4095);
        chk("max.aligned_pre", 64'(bus.aligned_o), 64'd0);
        chk("max.dly_act", 64'(bus.delay_act_o), 64'd4095);
        step(1'b1, DW'(4096));
        chk("max.aligned", 64'(bus.aligned_o), 64'd1);
        step(1'b1, DW'(4097));
        chk("max.en", 64'(bus.dout_en_o), 64'd1);
        chk("max.dout", 64'(bus.dout_o), 64'd1);
        chk("max.fill_sat", 64'(bus.fill_level_o), 64'd4095);
        step(1'b0, '0);
        chk("max.dout2", 64'(bus.dout_o), 64'd2);

`ifdef ENCODE_ALIGN_SIM_EN
        // sim mode: counter samples every cycle, D=2
        bus.delay_set_i = 12'd2;
        apply_reset();
        bus.sim_en_i = 1'b1;
        bus.din_i    = DW'('h3ff);
        tick();
        tick();
        tick();
        for (int j = 0; j < 6; j++) begin
            tick();
            chk($sformatf("sim.en%0d", j), 64'(bus.dout_en_o), 64'd1);
            chk($sformatf("sim.dout%0d", j), 64'(bus.dout_o), 64'(j));
        end
        bus.sim_en_i = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
